// File: rtl/i2c_line_conditioner.sv
// I2C receive front end: pin synchronizers, SCL edge and START/STOP detection, bus-busy.
// Define I2C_GLITCH_FILT_EN to insert a per-line glitch filter after the sync chains.
module i2c_line_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic SDA_in,
    input  logic SCL_in,
    output logic SDA_sync,
    output logic SCL_sync,
    output logic rising_edge,
    output logic falling_edge,
    output logic start_found,
    output logic stop_found,
    output logic bus_busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt
        $error("FILT_LEN must be 2..15");
    end

    logic [SYNC_STAGES-1:0] sda_chain;
    logic [SYNC_STAGES-1:0] scl_chain;
    logic                   sda_raw;
    logic                   scl_raw;
    logic                   sda_prev;
    logic                   scl_prev;

    // Chains reset high so an idle bus produces no edge at release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_chain <= '1;
            scl_chain <= '1;
        end else begin
            sda_chain <= {sda_chain[SYNC_STAGES-2:0], SDA_in};
            scl_chain <= {scl_chain[SYNC_STAGES-2:0], SCL_in};
        end
    end

    assign sda_raw = sda_chain[SYNC_STAGES-1];
    assign scl_raw = scl_chain[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILT_EN
    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    logic [3:0] sda_cnt;
    logic [3:0] scl_cnt;
    logic       sda_filt;
    logic       scl_filt;

    // A new level is accepted only after FILT_LEN consecutive mismatching samples.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_cnt  <= '0;
            scl_cnt  <= '0;
            sda_filt <= 1'b1;
            scl_filt <= 1'b1;
        end else begin
            if (sda_raw == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_MAX) begin
                sda_filt <= sda_raw;
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end

            if (scl_raw == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_MAX) begin
                scl_filt <= scl_raw;
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
        end
    end

    assign SDA_sync = sda_filt;
    assign SCL_sync = scl_filt;
`else
    assign SDA_sync = sda_raw;
    assign SCL_sync = scl_raw;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_prev <= 1'b1;
            scl_prev <= 1'b1;
            bus_busy <= 1'b0;
        end else begin
            sda_prev <= SDA_sync;
            scl_prev <= SCL_sync;
            if (start_found) begin
                bus_busy <= 1'b1;
            end else if (stop_found) begin
                bus_busy <= 1'b0;
            end
        end
    end

    assign rising_edge  = SCL_sync & ~scl_prev;
    assign falling_edge = ~SCL_sync & scl_prev;
    assign start_found  = SCL_sync & scl_prev & ~SDA_sync & sda_prev;
    assign stop_found   = SCL_sync & scl_prev & SDA_sync & ~sda_prev;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Bench for i2c_line_conditioner: history-based line model checked every cycle
// plus directed scenarios with literal cycle expectations.
module tb_i2c_line_conditioner;

    localparam int S    = 2;
    localparam int F    = 3;
    localparam int MAXC = 4095;
`ifdef I2C_GLITCH_FILT_EN
    localparam int LAT = S + F;
`else
    localparam int LAT = S;
`endif

    logic clk;
    logic n_rst;
    logic SDA_in;
    logic SCL_in;
    logic SDA_sync;
    logic SCL_sync;
    logic rising_edge;
    logic falling_edge;
    logic start_found;
    logic stop_found;
    logic bus_busy;

    i2c_line_conditioner #(
        .SYNC_STAGES(S),
        .FILT_LEN   (F)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .SDA_in      (SDA_in),
        .SCL_in      (SCL_in),
        .SDA_sync    (SDA_sync),
        .SCL_sync    (SCL_sync),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .start_found (start_found),
        .stop_found  (stop_found),
        .bus_busy    (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin level seen at each clock edge since the last reset release.
    bit h_scl [0:MAXC];
    bit h_sda [0:MAXC];
    bit s_scl [0:MAXC];
    bit s_sda [0:MAXC];
    int n;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            n = 0;
        end else if (n < MAXC) begin
            n = n + 1;
            h_scl[n] = SCL_in;
            h_sda[n] = SDA_in;
        end
    end

    int  passes;
    int  total;
    int  cur;
    bit  busy_m;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    endtask

    // Synchronized level after edge j: the pin as sampled S-1 edges earlier.
    function automatic bit chain(input bit sel, input int j);
        int idx;
        idx = j - S + 1;
        if (idx < 1) return 1'b1;
        return sel ? h_scl[idx] : h_sda[idx];
    endfunction

    function automatic bit model_level(input bit sel, input int m);
`ifdef I2C_GLITCH_FILT_EN
        bit f;
        bit flip;
        f = sel ? s_scl[m-1] : s_sda[m-1];
        flip = (m - F >= 0);
        for (int j = m - F; j <= m - 1; j++) begin
            if (flip && chain(sel, j) == f) flip = 1'b0;
        end
        return flip ? ~f : f;
`else
        return chain(sel, m);
`endif
    endfunction

    task automatic tick();
        bit sc, scp, sd, sdp;
        bit e_start, e_stop;
        @(negedge clk);
        cur++;
        if (!n_rst) busy_m = 1'b0;
        if (n == 0) begin
            s_scl[0] = 1'b1;
            s_sda[0] = 1'b1;
        end else begin
            s_scl[n] = model_level(1'b1, n);
            s_sda[n] = model_level(1'b0, n);
        end
        sc  = s_scl[n];
        sd  = s_sda[n];
        scp = (n == 0) ? 1'b1 : s_scl[n-1];
        sdp = (n == 0) ? 1'b1 : s_sda[n-1];
        e_start = sc && scp && !sd && sdp;
        e_stop  = sc && scp && sd && !sdp;
        chk("m_SCL_sync", SCL_sync, sc);
        chk("m_SDA_sync", SDA_sync, sd);
        chk("m_rising", rising_edge, sc & ~scp);
        chk("m_falling", falling_edge, ~sc & scp);
        chk("m_start", start_found, e_start);
        chk("m_stop", stop_found, e_stop);
        chk("m_busy", bus_busy, busy_m);
        if (e_start) busy_m = 1'b1;
        else if (e_stop) busy_m = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cur < c) tick();
    endtask

    task automatic begin0();
        cur = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_at(input int c);
        goto(c - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit any;
        passes = 0;
        total  = 0;
        busy_m = 1'b0;
        cur    = 0;
        SDA_in = 1'b1;
        SCL_in = 1'b1;
        n_rst  = 1'b0;
        repeat (3) tick();
        chk("rst_SDA_sync", SDA_sync, 1'b1);
        chk("rst_SCL_sync", SCL_sync, 1'b1);
        chk("rst_busy", bus_busy, 1'b0);
        begin0();
        n_rst = 1'b1;
        any = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            goto(i);
            any |= rising_edge | falling_edge | start_found | stop_found;
        end
        chk("rst_no_pulse", any, 1'b0);

        begin0(); SCL_in = 1'b0; goto(10);
        begin0(); SCL_in = 1'b1;
        goto(LAT - 1); chk("rise_early", rising_edge, 1'b0);
        goto(LAT);     chk("rise", rising_edge, 1'b1);
        chk("rise_scl", SCL_sync, 1'b1);
        goto(LAT + 1); chk("rise_once", rising_edge, 1'b0);
        drive_at(10); SCL_in = 1'b0;
        goto(LAT + 9);  chk("fall_early", falling_edge, 1'b0);
        goto(LAT + 10); chk("fall", falling_edge, 1'b1);
        goto(LAT + 11); chk("fall_once", falling_edge, 1'b0);

        begin0(); SCL_in = 1'b1; goto(10);
        begin0(); SDA_in = 1'b0;
        goto(LAT);     chk("start", start_found, 1'b1);
        chk("start_busy0", bus_busy, 1'b0);
        goto(LAT + 1); chk("start_busy1", bus_busy, 1'b1);
        chk("start_once", start_found, 1'b0);
        drive_at(20); SDA_in = 1'b1;
        goto(LAT + 20); chk("stop", stop_found, 1'b1);
        chk("stop_busy1", bus_busy, 1'b1);
        goto(LAT + 21); chk("stop_busy0", bus_busy, 1'b0);

        begin0(); SCL_in = 1'b0; SDA_in = 1'b0;
        goto(LAT);     chk("simul_fall", falling_edge, 1'b1);
        chk("simul_nostart", start_found, 1'b0);
        goto(LAT + 1); chk("simul_busy", bus_busy, 1'b0);
        goto(10);

        begin0(); SCL_in = 1'b1; goto(10);
        begin0(); SDA_in = 1'b1;
        goto(LAT);     chk("idle_stop", stop_found, 1'b1);
        goto(LAT + 1); chk("idle_stop_busy", bus_busy, 1'b0);
        goto(10);
        begin0(); SDA_in = 1'b0;
        goto(LAT + 1); chk("busy_set", bus_busy, 1'b1);
        goto(10);
        begin0(); SCL_in = 1'b0;
        drive_at(6);  SDA_in = 1'b1;
        drive_at(12); SCL_in = 1'b1;
        drive_at(20); SDA_in = 1'b0;
        goto(LAT + 20); chk("rstart", start_found, 1'b1);
        chk("rstart_busy", bus_busy, 1'b1);
        goto(LAT + 21); chk("rstart_hold", bus_busy, 1'b1);

        begin0(); SCL_in = 1'b0;
        drive_at(5); SDA_in = 1'b0;
        goto(12); chk("mid_busy", bus_busy, 1'b1);
        #3 n_rst = 1'b0;
        #1;
        chk("arst_busy", bus_busy, 1'b0);
        chk("arst_scl", SCL_sync, 1'b1);
        chk("arst_sda", SDA_sync, 1'b1);
        repeat (3) tick();
        begin0(); n_rst = 1'b1;
        goto(LAT - 1); chk("rel_fall_early", falling_edge, 1'b0);
        goto(LAT);     chk("rel_fall", falling_edge, 1'b1);
        chk("rel_nostart", start_found, 1'b0);
        goto(LAT + 1); chk("rel_fall_once", falling_edge, 1'b0);
        goto(20);

`ifdef I2C_GLITCH_FILT_EN
        begin0(); SCL_in = 1'b1; SDA_in = 1'b1; goto(15);
        begin0(); SCL_in = 1'b0;
        drive_at(2); SCL_in = 1'b1;
        any = 1'b0;
        for (int i = 0; i <= 15; i++) begin
            goto(i);
            any |= falling_edge;
        end
        chk("glitch2_reject", any, 1'b0);
        begin0(); SCL_in = 1'b0;
        drive_at(3); SCL_in = 1'b1;
        goto(4); chk("glitch3_early", falling_edge, 1'b0);
        goto(5); chk("glitch3_fall", falling_edge, 1'b1);
        goto(6); chk("glitch3_once", falling_edge, 1'b0);
        goto(15);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
